// File: rtl/node_writeback_unit.sv
// Buffers node results in a small FIFO and drains them to node RAM with a ready handshake.
// Optional macro NODE_WRITEBACK_SLOT_CHECK_EN drops and flags pushes whose slot_sig is not one-hot.
module node_writeback_unit #(
  parameter int width                  = 32,
  parameter int number_of_node_in_core = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [number_of_node_in_core-1:0] slot_sig,
  input  logic                              is_enable,
  input  logic                              result_valid,
  input  logic [width-1:0]                  result_data,
  input  logic                              ram_wr_ready,
  output logic                              ram_wr_en,
  output logic [width-1:0]                  ram_wr_address,
  output logic [width-1:0]                  ram_wr_data,
  output logic                              frame_done,
  output logic                              overflow,
  output logic                              slot_error
);

  localparam int PW = (number_of_node_in_core > 1) ? $clog2(number_of_node_in_core) : 1;
  localparam int CW = $clog2(number_of_node_in_core + 1);
  localparam logic [PW-1:0]    LAST_PTR  = PW'(number_of_node_in_core - 1);
  localparam logic [CW-1:0]    DEPTH     = CW'(number_of_node_in_core);
  localparam logic [width-1:0] LAST_ADDR = width'(number_of_node_in_core - 1);

  logic [width-1:0] addr_mem [number_of_node_in_core];
  logic [width-1:0] data_mem [number_of_node_in_core];

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          frame_done_reg, overflow_reg, slot_error_reg;

  logic [width-1:0] slot_index;
  logic             capture, push_req, slot_bad;
  logic             full, not_empty, pop, push_accept, drop;

  // Lowest set bit wins; scanning downward lets the last assignment be the lowest index.
  always_comb begin
    slot_index = '0;
    for (int k = number_of_node_in_core - 1; k >= 0; k--) begin
      if (slot_sig[k]) slot_index = width'(k);
    end
  end

  assign capture = is_enable && result_valid;

`ifdef NODE_WRITEBACK_SLOT_CHECK_EN
  assign slot_bad = capture && !$onehot(slot_sig);
  assign push_req = capture && $onehot(slot_sig);
`else
  assign slot_bad = 1'b0;
  assign push_req = capture;
`endif

  assign full        = (count_reg == DEPTH);
  assign not_empty   = (count_reg != '0);
  assign pop         = not_empty && ram_wr_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_accept = push_req && (!full || pop);
  assign drop        = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (!reset && push_accept) begin
      addr_mem[wr_ptr_reg] <= slot_index;
      data_mem[wr_ptr_reg] <= result_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      slot_error_reg <= 1'b0;
    end else begin
      if (push_accept) wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)         rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      case ({push_accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      frame_done_reg <= pop && (addr_mem[rd_ptr_reg] == LAST_ADDR);
      if (drop)     overflow_reg   <= 1'b1;
      if (slot_bad) slot_error_reg <= 1'b1;
    end
  end

  // Head is gated so an empty FIFO always presents zeros, including straight after reset.
  assign ram_wr_en      = not_empty;
  assign ram_wr_address = not_empty ? addr_mem[rd_ptr_reg] : '0;
  assign ram_wr_data    = not_empty ? data_mem[rd_ptr_reg] : '0;
  assign frame_done     = frame_done_reg;
  assign overflow       = overflow_reg;
  assign slot_error     = slot_error_reg;

endmodule

// File: tb/tb_node_writeback_unit.sv
// Self-checking bench for node_writeback_unit; a negedge monitor scores RAM writes against a queue.
module tb_node_writeback_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  slot_sig = '0;
  logic        is_enable = 1'b0;
  logic        result_valid = 1'b0;
  logic [31:0] result_data = '0;
  logic        ram_wr_ready = 1'b0;
  logic        ram_wr_en;
  logic [31:0] ram_wr_address;
  logic [31:0] ram_wr_data;
  logic        frame_done;
  logic        overflow;
  logic        slot_error;

  int vectors = 0;
  int miscompares = 0;
  int writes = 0;
  bit armed = 1'b0;
  bit exp_fd = 1'b0;
  logic [63:0] sb[$];

  node_writeback_unit #(.width(32), .number_of_node_in_core(5)) dut (
    .clk(clk), .reset(reset), .slot_sig(slot_sig), .is_enable(is_enable),
    .result_valid(result_valid), .result_data(result_data), .ram_wr_ready(ram_wr_ready),
    .ram_wr_en(ram_wr_en), .ram_wr_address(ram_wr_address), .ram_wr_data(ram_wr_data),
    .frame_done(frame_done), .overflow(overflow), .slot_error(slot_error)
  );

  always #5 clk = ~clk;

  // Monitor: a write is accepted at the next posedge when en and ready are both high now.
  always @(negedge clk) begin
    if (armed) begin
      if (reset) begin
        sb.delete();
        exp_fd = 1'b0;
      end else begin
        logic [63:0] exp_wr;
        vectors++;
        if (frame_done !== exp_fd) begin
          miscompares++;
          $display("FAIL frame_done: got %b want %b", frame_done, exp_fd);
        end
        exp_fd = 1'b0;
        if (ram_wr_en === 1'b1 && ram_wr_ready) begin
          writes++;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got addr=%0d data=%h want no write", ram_wr_address, ram_wr_data);
          end else begin
            exp_wr = sb.pop_front();
            if ({ram_wr_address, ram_wr_data} !== exp_wr) begin
              miscompares++;
              $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                       ram_wr_address, ram_wr_data, exp_wr[63:32], exp_wr[31:0]);
            end else begin
              $display("write addr=%0d data=%h", ram_wr_address, ram_wr_data);
            end
            exp_fd = (exp_wr[63:32] == 32'd4);
          end
        end
      end
    end
  end

  task automatic set_idle();
    slot_sig = '0; is_enable = 1'b0; result_valid = 1'b0; result_data = '0;
  endtask

  task automatic drive_push(input int slot, input logic [31:0] d, input bit accepted);
    slot_sig = 5'(1 << slot); is_enable = 1'b1; result_valid = 1'b1; result_data = d;
    if (accepted) sb.push_back({32'(slot), d});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    set_idle(); ram_wr_ready = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    armed = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ram_wr_en, ram_wr_address, ram_wr_data, frame_done, overflow, slot_error} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h fd=%b ov=%b se=%b want all 0",
               ram_wr_en, ram_wr_address, ram_wr_data, frame_done, overflow, slot_error);
    end
  endtask

  task automatic test_basic();
    int w0;
    do_reset();
    ram_wr_ready = 1'b1;
    w0 = writes;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      drive_push(k, 32'hA0 + 32'(k), 1'b1);
      if (k > 0) begin
        @(negedge clk);
        vectors++;
        if (ram_wr_en !== 1'b1 || ram_wr_address !== 32'(k - 1) || ram_wr_data !== 32'hA0 + 32'(k - 1)) begin
          miscompares++;
          $display("FAIL basic_latency: got en=%b addr=%0d data=%h want en=1 addr=%0d", ram_wr_en,
                   ram_wr_address, ram_wr_data, k - 1);
        end
      end
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    vectors++;
    if (ram_wr_en !== 1'b1 || ram_wr_address !== 32'd4 || ram_wr_data !== 32'hA4) begin
      miscompares++;
      $display("FAIL basic_last: got en=%b addr=%0d data=%h want en=1 addr=4 data=a4", ram_wr_en, ram_wr_address, ram_wr_data);
    end
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b1 || ram_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_frame_done: got fd=%b en=%b want fd=1 en=0", frame_done, ram_wr_en);
    end
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b0 || writes - w0 != 5) begin
      miscompares++;
      $display("FAIL basic_count: got fd=%b writes=%0d want fd=0 writes=5", frame_done, writes - w0);
    end
  endtask

  task automatic test_overflow();
    int w0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive_push(k % 5, 32'hD0 + 32'(k), k < 5);
    end
    @(posedge clk); #1;
    set_idle();
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (overflow !== 1'b1 || ram_wr_en !== 1'b1 || ram_wr_address !== 32'd0 || ram_wr_data !== 32'hD0) begin
        miscompares++;
        $display("FAIL overflow_hold: got ov=%b en=%b addr=%0d data=%h want ov=1 en=1 addr=0 data=d0",
                 overflow, ram_wr_en, ram_wr_address, ram_wr_data);
      end
    end
    @(posedge clk); #1;
    w0 = writes;
    ram_wr_ready = 1'b1;
    for (int i = 0; i < 30 && (sb.size() != 0 || ram_wr_en !== 1'b0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (writes - w0 != 5 || sb.size() != 0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_drain: got writes=%0d pending=%0d ov=%b want writes=5 pending=0 ov=1",
               writes - w0, sb.size(), overflow);
    end
  endtask

  task automatic test_full_push_pop();
    int w0;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      drive_push(k, 32'hB0 + 32'(k), 1'b1);
    end
    @(posedge clk); #1;
    w0 = writes;
    ram_wr_ready = 1'b1;
    drive_push(2, 32'hC0, 1'b1);
    @(posedge clk); #1;
    ram_wr_ready = 1'b0;
    set_idle();
    @(negedge clk);
    vectors++;
    if (overflow !== 1'b0 || ram_wr_address !== 32'd1 || ram_wr_data !== 32'hB1) begin
      miscompares++;
      $display("FAIL full_push_pop: got ov=%b addr=%0d data=%h want ov=0 addr=1 data=b1", overflow, ram_wr_address, ram_wr_data);
    end
    @(posedge clk); #1;
    drive_push(3, 32'hC1, 1'b0);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL full_still_full: got ov=%b want ov=1", overflow);
    end
    @(posedge clk); #1;
    ram_wr_ready = 1'b1;
    for (int i = 0; i < 30 && (sb.size() != 0 || ram_wr_en !== 1'b0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    vectors++;
    if (writes - w0 != 6 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL full_drain: got writes=%0d pending=%0d want writes=6 pending=0", writes - w0, sb.size());
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      slot_sig = 5'b00010; is_enable = 1'b0; result_valid = 1'b1; result_data = 32'h55 + 32'(k);
      @(negedge clk);
      vectors++;
      if (ram_wr_en !== 1'b0) begin
        miscompares++;
        $display("FAIL enable_low: got en=%b want en=0", ram_wr_en);
      end
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    vectors++;
    if (ram_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_after: got en=%b want en=0", ram_wr_en);
    end
  endtask

  task automatic test_slot();
    do_reset();
    ram_wr_ready = 1'b1;
    @(posedge clk); #1;
    slot_sig = 5'b00011; is_enable = 1'b1; result_valid = 1'b1; result_data = 32'hE0;
`ifndef NODE_WRITEBACK_SLOT_CHECK_EN
    sb.push_back({32'd0, 32'hE0});
`endif
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    vectors++;
`ifdef NODE_WRITEBACK_SLOT_CHECK_EN
    if (ram_wr_en !== 1'b0 || slot_error !== 1'b1) begin
      miscompares++;
      $display("FAIL slot_check: got en=%b se=%b want en=0 se=1", ram_wr_en, slot_error);
    end
`else
    if (ram_wr_en !== 1'b1 || ram_wr_address !== 32'd0 || ram_wr_data !== 32'hE0 || slot_error !== 1'b0) begin
      miscompares++;
      $display("FAIL slot_lowest: got en=%b addr=%0d data=%h se=%b want en=1 addr=0 data=e0 se=0",
               ram_wr_en, ram_wr_address, ram_wr_data, slot_error);
    end
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_pending();
    int w0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drive_push(k + 1, 32'hF0 + 32'(k), 1'b1);
    end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    vectors++;
    if (ram_wr_en !== 1'b1 || ram_wr_address !== 32'd1) begin
      miscompares++;
      $display("FAIL pending: got en=%b addr=%0d want en=1 addr=1", ram_wr_en, ram_wr_address);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ram_wr_en, ram_wr_address, ram_wr_data, frame_done, overflow, slot_error} !== '0) begin
      miscompares++;
      $display("FAIL reset_pending: got en=%b addr=%h data=%h fd=%b ov=%b se=%b want all 0",
               ram_wr_en, ram_wr_address, ram_wr_data, frame_done, overflow, slot_error);
    end
    w0 = writes;
    ram_wr_ready = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (writes != w0 || ram_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_write: got writes=%0d en=%b want writes=0 en=0", writes - w0, ram_wr_en);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_enable();
    test_slot();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
